// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: control state
// encoding and the bit-counter width helper.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic element in the serial adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one full-adder cell, WIDTH cycles per add, results
// registered on entry to DONE and held until the next accepted start.
module bit_serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = cnt_width(WIDTH);

  // Handshake: start is a request sampled on a rising edge; it is accepted
  // only when the FSM is in IDLE or DONE, and ignored (not queued) in SHIFT.
  // done is a one-cycle pulse; sum/cout/ovf are valid from that cycle on.

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-2:0]   sum_sr_q, sum_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_s, fa_c;
  logic               load;
  logic [WIDTH-1:0]   sum_next;

  full_adder_cell u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign load     = start && (state_q == IDLE || state_q == DONE);
  assign sum_next = {fa_s, sum_sr_q};

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    if (load) begin
      state_d  = SHIFT;
      a_sr_d   = a;
      b_sr_d   = b;
      sum_sr_d = '0;
      carry_d  = cin;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SHIFT: begin
          a_sr_d   = a_sr_q >> 1;
          b_sr_d   = b_sr_q >> 1;
          sum_sr_d = sum_next[WIDTH-1:1];
          carry_d  = fa_c;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            // Final bit: carry_q is the carry into the MSB.
            state_d = DONE;
            sum_d   = sum_next;
            cout_d  = fa_c;
            ovf_d   = carry_q ^ fa_c;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder (WIDTH=8) with hand-computed results.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int tests_run;
  int tests_failed;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // One start pulse, then wait (bounded) for done. lat = edges after the
  // accepting edge until done is seen, -1 on timeout. Leaves the bench in the
  // done cycle.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, output int lat, output int busy_cnt);
    @(posedge clk); #1;
    a_i = av; b_i = bv; cin_i = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic check_vec(input string name, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic cv,
                           input logic [W-1:0] es, input logic ec,
                           input logic eo);
    int lat, bc;
    do_op(av, bv, cv, lat, bc);
    tests_run++;
    if (lat !== W) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, W);
    end
    tests_run++;
    if ({sum, cout, ovf} !== {es, ec, eo}) begin
      tests_failed++;
      $display("FAIL %s result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, es, ec, eo);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tests_run++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy, done, sum, cout, ovf);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    do_op(8'h3C, 8'h05, 1'b0, lat, bc);
    tests_run++;
    if (lat !== 8) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    tests_run++;
    if (bc !== 8) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles: got %0d expected 8", bc);
    end
    tests_run++;
    if ({sum, cout, ovf, busy} !== {8'h41, 1'b0, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_result: got sum=%h cout=%b ovf=%b busy=%b expected 41 0 0 0",
               sum, cout, ovf, busy);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({done, busy, sum} !== {1'b0, 1'b0, 8'h41}) begin
      tests_failed++;
      $display("FAIL basic_hold: got done=%b busy=%b sum=%h expected 0 0 41", done, busy, sum);
    end
  endtask

  task automatic test_carry_wrap();
    check_vec("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    check_vec("wrap_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    check_vec("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    check_vec("ovf_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_start_ignored();
    int lat, dones;
    @(posedge clk); #1;
    a_i = 8'h10; b_i = 8'h20; cin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_i = 8'hAA; b_i = 8'h55; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = -1;
    for (int k = 4; k <= 20; k++) begin
      if (done) begin
        lat = k - 1;
        break;
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (lat !== 8 || sum !== 8'h30) begin
      tests_failed++;
      $display("FAIL ignore_result: got lat=%0d sum=%h expected lat=8 sum=30", lat, sum);
    end
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL ignore_single_done: got %0d extra done pulses expected 0", dones);
    end
    check_vec("ignore_restart", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int first, second, bad;
    logic [W-1:0] s1, s2;
    @(posedge clk); #1;
    a_i = 8'h01; b_i = 8'h02; cin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a_i = 8'h04; b_i = 8'h08;
    first = -1; second = -1; bad = 0; s1 = '0; s2 = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (busy === done) bad++;
      if (done) begin
        if (first < 0) begin
          first = k; s1 = sum;
        end else begin
          second = k; s2 = sum;
          break;
        end
      end
    end
    start = 1'b0;
    tests_run++;
    if (first !== 8 || second - first !== 9) begin
      tests_failed++;
      $display("FAIL b2b_timing: got first=%0d gap=%0d expected 8 and 9", first, second - first);
    end
    tests_run++;
    if (s1 !== 8'h03 || s2 !== 8'h0C) begin
      tests_failed++;
      $display("FAIL b2b_sums: got %h then %h expected 03 then 0c", s1, s2);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL b2b_busy: got %0d cycles with busy==done expected 0", bad);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({busy, done, sum} !== {1'b0, 1'b0, 8'h0C}) begin
      tests_failed++;
      $display("FAIL b2b_idle: got busy=%b done=%b sum=%h expected 0 0 0c", busy, done, sum);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    @(posedge clk); #1;
    a_i = 8'h3C; b_i = 8'h05; cin_i = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    tests_run++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
               busy, done, sum, cout, ovf);
    end
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: got %0d active cycles expected 0", dones);
    end
    // rst and start on the same edge: start must be dropped.
    rst = 1'b1; start = 1'b1; a_i = 8'h11; b_i = 8'h22;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_beats_start: got busy=%b expected 0", busy);
    end
    check_vec("after_reset", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0);
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_carry_wrap();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
